// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run controller: host command opcodes, run-state
// values and default parameter values.
package cpu_ctrl_pkg;

  localparam logic [15:0] PcResetDefault    = 16'd10;
  localparam logic [3:0]  HaltOpcodeDefault = 4'hF;
  localparam int unsigned CntWDefault       = 32;

  typedef enum logic [2:0] {
    CmdNop      = 3'd0,
    CmdLoadAddr = 3'd1,
    CmdLoadWord = 3'd2,
    CmdRun      = 3'd3,
    CmdStep     = 3'd4,
    CmdHalt     = 3'd5,
    CmdSetBp    = 3'd6,
    CmdSetPc    = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StHalted = 3'd3
  } run_state_e;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Bundle of host-command, datapath and instruction-memory signals around the
// run controller. The controller uses the slave view; the host/datapath side
// uses the master view.
interface cpu_run_controller_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [15:0]      cmd_data;
  logic [15:0]      pc_current;
  logic [3:0]       opcode;
  logic             pc_en;
  logic             pc_load;
  logic [15:0]      pc_load_val;
  logic             imem_we;
  logic [15:0]      imem_addr;
  logic [15:0]      imem_wdata;
  logic [2:0]       run_state;
  logic             bp_hit;
  logic [CNT_W-1:0] retired;

  modport master (
    output cmd_valid, cmd_op, cmd_data, pc_current, opcode,
    input  cmd_ready, pc_en, pc_load, pc_load_val, imem_we, imem_addr, imem_wdata,
    input  run_state, bp_hit, retired
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, pc_current, opcode,
    output cmd_ready, pc_en, pc_load, pc_load_val, imem_we, imem_addr, imem_wdata,
    output run_state, bp_hit, retired
  );

endinterface

// File: rtl/cpu_retire_counter.sv
// Saturating retired-instruction counter: counts one per asserted increment,
// sticks at all-ones, synchronous clear.
module cpu_retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count increments, holding at the maximum value instead of wrapping
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the 16-bit single-cycle datapath: loads instruction
// memory, sets the PC, runs, single-steps and halts the core.
// Optional feature: define CPU_BREAKPOINT_EN to enable the breakpoint register,
// breakpoint stop and the sticky bp_hit flag; otherwise SET_BP is a no-op.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter logic [15:0] PC_RESET    = PcResetDefault,
  parameter logic [3:0]  HALT_OPCODE = HaltOpcodeDefault,
  parameter int unsigned CNT_W       = CntWDefault
) (
  input logic                 Clock,
  input logic                 Reset,
  cpu_run_controller_if.slave bus
);

  run_state_e       r_state;
  run_state_e       w_state_next;
  logic [15:0]      r_ptr;
  logic             r_pc_load;
  logic [15:0]      r_pc_load_val;
  logic             r_we;
  logic [15:0]      r_waddr;
  logic [15:0]      r_wdata;

  cmd_op_e          w_op;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_ctl_acc;
  logic             w_halt_cmd;
  logic             w_halt_fetch;
  logic             w_bp_match;
  logic             w_pc_en;
  logic [CNT_W-1:0] w_retired;

  assign w_op         = cmd_op_e'(bus.cmd_op);
  assign w_cmd_ready  = (r_state != StStep);
  assign w_accept     = bus.cmd_valid & w_cmd_ready;
  // Commands that act on memory/PC/breakpoint are only honoured while stopped
  assign w_ctl_acc    = w_accept & ((r_state == StIdle) | (r_state == StHalted));
  assign w_halt_cmd   = w_accept & (r_state == StRun) & (w_op == CmdHalt);
  assign w_halt_fetch = (bus.opcode == HALT_OPCODE);

  // Next run state and PC-enable; stop checks look at the instruction being fetched now.
  // pc_load is only ever raised the cycle after a stopped-state command, so it never
  // overlaps a RUN/STEP cycle and pc_en needs no extra gating.
  always_comb begin
    w_state_next = r_state;
    w_pc_en      = 1'b0;
    unique case (r_state)
      StIdle, StHalted: begin
        if (w_ctl_acc && (w_op == CmdRun)) begin
          w_state_next = StRun;
        end else if (w_ctl_acc && (w_op == CmdStep)) begin
          w_state_next = StStep;
        end
      end
      StRun: begin
        if (w_halt_cmd || w_halt_fetch || w_bp_match) begin
          w_state_next = StHalted;
        end else begin
          w_pc_en = 1'b1;
        end
      end
      StStep: begin
        w_pc_en      = 1'b1;
        w_state_next = StHalted;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State, load pointer, PC-load request and registered imem write port
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= StIdle;
      r_ptr         <= 16'h0000;
      r_pc_load     <= 1'b1;
      r_pc_load_val <= PC_RESET;
      r_we          <= 1'b0;
      r_waddr       <= 16'h0000;
      r_wdata       <= 16'h0000;
    end else begin
      r_state   <= w_state_next;
      r_pc_load <= 1'b0;
      r_we      <= 1'b0;
      if (w_ctl_acc) begin
        unique case (w_op)
          CmdLoadAddr: r_ptr <= bus.cmd_data & 16'hFFFE;
          CmdLoadWord: begin
            r_we    <= 1'b1;
            r_waddr <= r_ptr;
            r_wdata <= bus.cmd_data;
            r_ptr   <= r_ptr + 16'd2;
          end
          CmdSetPc: begin
            r_pc_load     <= 1'b1;
            r_pc_load_val <= bus.cmd_data;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CPU_BREAKPOINT_EN
  logic [15:0] r_bp;
  logic        r_bp_valid;
  logic        r_skip_bp;
  logic        r_bp_hit;

  // The first RUN cycle after a halt ignores the breakpoint so a resume executes it
  assign w_bp_match = r_bp_valid & (bus.pc_current == r_bp) & ~r_skip_bp;

  // Breakpoint address, resume-skip flag and sticky hit flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_bp       <= 16'h0000;
      r_bp_valid <= 1'b0;
      r_skip_bp  <= 1'b0;
      r_bp_hit   <= 1'b0;
    end else begin
      if (w_ctl_acc && (w_op == CmdSetBp)) begin
        r_bp       <= bus.cmd_data;
        r_bp_valid <= 1'b1;
      end
      if (w_ctl_acc && (w_op == CmdRun)) begin
        r_skip_bp <= (r_state == StHalted);
      end else if (r_state == StRun) begin
        r_skip_bp <= 1'b0;
      end
      if (w_ctl_acc && ((w_op == CmdRun) || (w_op == CmdStep))) begin
        r_bp_hit <= 1'b0;
      end else if ((r_state == StRun) && !w_halt_cmd && w_bp_match) begin
        r_bp_hit <= 1'b1;
      end
    end
  end

  assign bus.bp_hit = r_bp_hit;
`else
  assign w_bp_match = 1'b0;
  assign bus.bp_hit = 1'b0;
`endif

  cpu_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .i_clk   (Clock),
    .i_clr   (Reset),
    .i_inc   (w_pc_en),
    .o_count (w_retired)
  );

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.pc_en       = w_pc_en;
  assign bus.pc_load     = r_pc_load;
  assign bus.pc_load_val = r_pc_load_val;
  assign bus.imem_we     = r_we;
  assign bus.imem_addr   = r_waddr;
  assign bus.imem_wdata  = r_wdata;
  assign bus.run_state   = r_state;
  assign bus.retired     = w_retired;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: small datapath/imem model around the DUT,
// expected PC-load / PC-enable / imem-write events queued by the stimulus and
// consumed by a monitor at the falling edge.
module tb_cpu_run_controller;
  import cpu_ctrl_pkg::*;

  localparam int KWe   = 0;
  localparam int KLoad = 1;
  localparam int KEn   = 2;
`ifdef CPU_BREAKPOINT_EN
  localparam bit BpEn = 1'b1;
`else
  localparam bit BpEn = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  logic        clk;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  ev_t         exp_q[$];
  logic [15:0] tb_mem [64] = '{default: 16'h0};
  logic [15:0] tb_pc = 16'h0;

  cpu_run_controller_if #(.CNT_W(32)) ifc ();

  cpu_run_controller #(
    .PC_RESET    (16'd10),
    .HALT_OPCODE (4'hF),
    .CNT_W       (32)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: PC register and instruction memory
  assign ifc.pc_current = tb_pc;
  assign ifc.opcode     = tb_mem[tb_pc[6:1]][15:12];
  always @(posedge clk) begin
    if (ifc.imem_we) tb_mem[ifc.imem_addr[6:1]] <= ifc.imem_wdata;
    if (ifc.pc_load) tb_pc <= ifc.pc_load_val;
    else if (ifc.pc_en) tb_pc <= tb_pc + 16'd2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: actual kind %0d value %h, required none", kind, a);
    end else begin
      e = exp_q.pop_front();
      checks--;
      chk("event_kind", kind, e.kind);
      chk("event_value", {16'h0, a}, {16'h0, e.a});
      chk("event_data", {16'h0, d}, {16'h0, e.d});
    end
  endtask

  // Monitor: every strobe the DUT presents consumes one expected event
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.imem_we) pop_cmp(KWe, ifc.imem_addr, ifc.imem_wdata);
      if (ifc.pc_load) pop_cmp(KLoad, ifc.pc_load_val, 16'h0);
      if (ifc.pc_en)   pop_cmp(KEn, ifc.pc_current, 16'h0);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic send(input logic [2:0] op, input logic [15:0] data);
    bit rdy = 1'b0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_data  = data;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clk);
      rdy = ifc.cmd_ready;
      @(posedge clk);
      #1;
    end
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 3'd0;
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL cmd_accept: actual not accepted op %0d, required accepted", op);
    end
  endtask

  task automatic wait_halted(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ifc.run_state == 3'd3) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: actual run_state %0d, required 3 within budget", name, ifc.run_state);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 3'd0;
    ifc.cmd_data  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    push(KLoad, 16'd10, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", ifc.run_state, 32'd0);
    chk("reset_retired", ifc.retired, 32'd0);
    chk("reset_bp_hit", ifc.bp_hit, 32'd0);
    chk("reset_cmd_ready", ifc.cmd_ready, 32'd1);
    chk("reset_pc_load", ifc.pc_load, 32'd1);
    chk("reset_pc_en", ifc.pc_en, 32'd0);
    align();

    // Program: odd LOAD_ADDR is rounded down to 10
    send(3'd1, 16'd11);
    push(KWe, 16'd10, 16'h1234); send(3'd2, 16'h1234);
    push(KWe, 16'd12, 16'h2345); send(3'd2, 16'h2345);
    push(KWe, 16'd14, 16'hF000); send(3'd2, 16'hF000);
    push(KWe, 16'd16, 16'h0000); send(3'd2, 16'h0000);

    // RUN from 10 stops on the halt opcode at 14
    push(KEn, 16'd10, 16'h0);
    push(KEn, 16'd12, 16'h0);
    send(3'd3, 16'h0);
    wait_halted("run_halt_opcode");
    chk("run1_retired", ifc.retired, 32'd2);
    chk("run1_pc", {16'h0, tb_pc}, 32'd14);
    chk("run1_pc_en_low", ifc.pc_en, 32'd0);
    align();

    // Breakpoint at 12, then resume past it
    push(KLoad, 16'd10, 16'h0);
    send(3'd7, 16'd10);
    send(3'd6, 16'd12);
    push(KEn, 16'd10, 16'h0);
    if (!BpEn) push(KEn, 16'd12, 16'h0);
    send(3'd3, 16'h0);
    wait_halted("run_bp");
    chk("bp_stop_pc", {16'h0, tb_pc}, BpEn ? 32'd12 : 32'd14);
    chk("bp_hit_set", ifc.bp_hit, {31'h0, BpEn});
    chk("bp_retired", ifc.retired, BpEn ? 32'd3 : 32'd4);
    align();
    if (BpEn) push(KEn, 16'd12, 16'h0);
    send(3'd3, 16'h0);
    wait_halted("run_resume");
    chk("resume_pc", {16'h0, tb_pc}, 32'd14);
    chk("resume_bp_hit", ifc.bp_hit, 32'd0);
    chk("resume_retired", ifc.retired, 32'd4);
    align();

    // Two single steps; the first executes the halt opcode at 14
    push(KEn, 16'd14, 16'h0);
    send(3'd4, 16'h0);
    @(negedge clk);
    chk("step1_state", ifc.run_state, 32'd2);
    chk("step1_ready", ifc.cmd_ready, 32'd0);
    @(negedge clk);
    chk("step1_halted", ifc.run_state, 32'd3);
    chk("step1_retired", ifc.retired, 32'd5);
    align();
    push(KEn, 16'd16, 16'h0);
    send(3'd4, 16'h0);
    @(negedge clk);
    chk("step2_state", ifc.run_state, 32'd2);
    @(negedge clk);
    chk("step2_retired", ifc.retired, 32'd6);
    chk("step2_pc", {16'h0, tb_pc}, 32'd18);
    align();

    // RUN, LOAD_WORD dropped while running, HALT stops in its accept cycle
    push(KEn, 16'd18, 16'h0);
    send(3'd3, 16'h0);
    send(3'd2, 16'hBEEF);
    send(3'd5, 16'h0);
    @(negedge clk);
    chk("halt_cmd_state", ifc.run_state, 32'd3);
    chk("halt_cmd_retired", ifc.retired, 32'd7);
    chk("halt_cmd_pc", {16'h0, tb_pc}, 32'd20);
    align();
    push(KWe, 16'd18, 16'h5555); send(3'd2, 16'h5555);

    // Load pointer wraps from FFFE to 0
    send(3'd1, 16'hFFFF);
    push(KWe, 16'hFFFE, 16'hAAAA); send(3'd2, 16'hAAAA);
    push(KWe, 16'h0000, 16'h0BBB); send(3'd2, 16'h0BBB);

    // Reset in the middle of a run
    push(KLoad, 16'd20, 16'h0);
    send(3'd7, 16'd20);
    push(KEn, 16'd20, 16'h0);
    send(3'd3, 16'h0);
    align();
    rst = 1'b1;
    align();
    push(KLoad, 16'd10, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_reset_state", ifc.run_state, 32'd0);
    chk("midrun_reset_retired", ifc.retired, 32'd0);
    chk("midrun_reset_pc_en", ifc.pc_en, 32'd0);
    chk("midrun_reset_we", ifc.imem_we, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
